// File: rtl/key_note_encoder.sv
// Piano key front end: synchronises and debounces the key switches and emits a one-hot {note, pitch} code.
// Define NOTE_REPEAT_EN to re-strobe note_valid every REPEAT_CYCLES while a key stays held.
module key_note_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_CYCLES   = 50000000,
  parameter int unsigned CNT_W           = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] keys,
  input  logic [1:0] octave,
  input  logic       enable,
  output logic [9:0] note_and_pitch,
  output logic       note_valid,
  output logic       key_held
);

  // Acceptance happens on the cycle the counter would step to DEBOUNCE_CYCLES-1
  localparam int unsigned DB_LAST = (DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0;
  localparam int unsigned CNT_NEED = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
  localparam bit CFG_OK = (CNT_W >= 32) || (64'(CNT_NEED) < (64'(1) << CNT_W));

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

  state_t           state, state_d;
  logic [6:0]       keys_s1, ks;
  logic [1:0]       oct_s1, oct_s;
  logic [6:0]       cand, cand_d;
  logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;
  logic [9:0]       nap_d;
  logic             valid_d, held_d;
  logic             single;

`ifdef NOTE_REPEAT_EN
  localparam int unsigned REP_LAST = (REPEAT_CYCLES >= 1) ? REPEAT_CYCLES - 1 : 0;
  logic [CNT_W-1:0] rep, rep_d;
`endif

  function automatic logic [2:0] pitch_of(input logic [1:0] o);
    case (o)
      2'b00:   pitch_of = 3'b001;
      2'b10:   pitch_of = 3'b100;
      default: pitch_of = 3'b010;
    endcase
  endfunction

  assign single  = (ks != 7'd0) && ((ks & (ks - 7'd1)) == 7'd0);
  assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

  // Next-state and next-output logic
  always_comb begin
    state_d = state;
    cand_d  = cand;
    cnt_d   = cnt;
    nap_d   = note_and_pitch;
    valid_d = 1'b0;
    held_d  = key_held;
`ifdef NOTE_REPEAT_EN
    rep_d   = rep;
`endif
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      nap_d   = '0;
      held_d  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          nap_d  = '0;
          held_d = 1'b0;
          if (single) begin
            cand_d  = ks;
            cnt_d   = '0;
            state_d = PRESS_DB;
          end
        end
        PRESS_DB: begin
          if (ks != cand) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else if (cnt >= CNT_W'(DB_LAST)) begin
            cnt_d   = '0;
            nap_d   = {cand, pitch_of(oct_s)};
            valid_d = 1'b1;
            held_d  = 1'b1;
            state_d = HELD;
`ifdef NOTE_REPEAT_EN
            rep_d   = '0;
`endif
          end else begin
            cnt_d = cnt_inc;
          end
        end
        HELD: begin
          if (ks != cand) begin
            cnt_d   = '0;
            state_d = REL_DB;
          end
`ifdef NOTE_REPEAT_EN
          else if (rep >= CNT_W'(REP_LAST)) begin
            rep_d   = '0;
            valid_d = 1'b1;
          end else begin
            rep_d = rep + CNT_W'(1);
          end
`endif
        end
        REL_DB: begin
          if (ks == cand) begin
            cnt_d   = '0;
            state_d = HELD;
`ifdef NOTE_REPEAT_EN
            rep_d   = '0;
`endif
          end else if (cnt >= CNT_W'(DB_LAST)) begin
            cnt_d   = '0;
            nap_d   = '0;
            held_d  = 1'b0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Synchronisers, state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keys_s1        <= '0;
      ks             <= '0;
      oct_s1         <= '0;
      oct_s          <= '0;
      state          <= IDLE;
      cand           <= '0;
      cnt            <= '0;
      note_and_pitch <= '0;
      note_valid     <= 1'b0;
      key_held       <= 1'b0;
`ifdef NOTE_REPEAT_EN
      rep            <= '0;
`endif
    end else begin
      keys_s1        <= keys;
      ks             <= keys_s1;
      oct_s1         <= octave;
      oct_s          <= oct_s1;
      state          <= state_d;
      cand           <= cand_d;
      cnt            <= cnt_d;
      note_and_pitch <= nap_d;
      note_valid     <= valid_d;
      key_held       <= held_d;
`ifdef NOTE_REPEAT_EN
      rep            <= rep_d;
`endif
    end
  end

`ifndef SYNTHESIS
  cnt_w_fits: assert property (@(posedge clk) CFG_OK)
    else $error("key_note_encoder: CNT_W cannot hold the debounce/repeat counts");
`endif

endmodule

// File: tb/tb_key_note_encoder.sv
// Scoreboard bench for key_note_encoder: expected strobes (cycle, code) are queued at stimulus time.
module tb_key_note_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] keys;
  logic [1:0] octave;
  logic       enable;
  logic [9:0] note_and_pitch;
  logic       note_valid;
  logic       key_held;

  int unsigned cyc = 0;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic        prev_valid = 1'b0;

  typedef struct {
    int unsigned cyc;
    logic [9:0]  code;
  } exp_t;
  exp_t sb[$];

  key_note_encoder #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_CYCLES  (10),
    .CNT_W          (26)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .keys          (keys),
    .octave        (octave),
    .enable        (enable),
    .note_and_pitch(note_and_pitch),
    .note_valid    (note_valid),
    .key_held      (key_held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_strobe(input int unsigned at, input logic [9:0] code);
    exp_t e;
    e.cyc  = at;
    e.code = code;
    sb.push_back(e);
  endtask

  // Pop and compare on every observed strobe
  always @(negedge clk) begin
    if (note_valid) begin
      check("no_back_to_back", 32'(prev_valid), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_strobe", 32'(note_and_pitch), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("strobe_code", 32'(note_and_pitch), 32'(e.code));
        check("strobe_cycle", cyc, e.cyc);
      end
    end
    prev_valid = note_valid;
  end

  initial begin
    rst    = 1'b1;
    keys   = '0;
    octave = 2'b01;
    enable = 1'b1;
    wait_cycles(3);
    check("rst_nap", 32'(note_and_pitch), 32'd0);
    check("rst_valid", 32'(note_valid), 32'd0);
    check("rst_held", 32'(key_held), 32'd0);
    rst = 1'b0;
    wait_cycles(4);

    // Clean press, then release debounce boundary
    keys = 7'b0000001;
    expect_strobe(cyc + 6, 10'b0000001_010);
    wait_cycles(8);
    check("t1_held", 32'(key_held), 32'd1);
    check("t1_nap", 32'(note_and_pitch), 32'(10'b0000001_010));
    keys = '0;
    wait_cycles(5);
    check("t1_held_before_rel", 32'(key_held), 32'd1);
    wait_cycles(1);
    check("t1_held_after_rel", 32'(key_held), 32'd0);
    check("t1_nap_after_rel", 32'(note_and_pitch), 32'd0);
    wait_cycles(3);

    // Bouncing key never accepted, then settles
    octave = 2'b10;
    for (int i = 0; i < 3; i++) begin
      keys = 7'b0000100;
      wait_cycles(2);
      keys = '0;
      wait_cycles(2);
    end
    keys = 7'b0000100;
    expect_strobe(cyc + 6, 10'b0000100_100);
    wait_cycles(8);
    keys = '0;
    wait_cycles(8);

    // Chord ignored, single key after it accepted
    octave = 2'b00;
    keys = 7'b0000011;
    wait_cycles(20);
    check("t3_chord_nap", 32'(note_and_pitch), 32'd0);
    check("t3_chord_held", 32'(key_held), 32'd0);
    keys = 7'b0000010;
    expect_strobe(cyc + 6, 10'b0000010_001);
    wait_cycles(8);
    keys = '0;
    wait_cycles(8);

    // Octave change and short release glitch while held
    octave = 2'b01;
    wait_cycles(3);
    keys = 7'b0001000;
    expect_strobe(cyc + 6, 10'b0001000_010);
    wait_cycles(8);
    octave = 2'b10;
    wait_cycles(2);
    keys = '0;
    wait_cycles(2);
    keys = 7'b0001000;
    wait_cycles(4);
    check("t4_nap_pitch_kept", 32'(note_and_pitch), 32'(10'b0001000_010));
    check("t4_held", 32'(key_held), 32'd1);
    keys = '0;
    wait_cycles(8);

    // Async reset mid press-debounce and mid held
    keys = 7'b0100000;
    wait_cycles(3);
    rst = 1'b1;
    #1;
    check("t5_rst_press_held", 32'(key_held), 32'd0);
    wait_cycles(1);
    rst = 1'b0;
    expect_strobe(cyc + 6, 10'b0100000_100);
    wait_cycles(8);
    check("t5_held_before_rst", 32'(key_held), 32'd1);
    rst = 1'b1;
    #1;
    check("t5_rst_nap", 32'(note_and_pitch), 32'd0);
    check("t5_rst_held", 32'(key_held), 32'd0);
    keys = '0;
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(4);

    // enable=0 clears on the next edge; re-enable with key down debounces from IDLE
    keys = 7'b1000000;
    expect_strobe(cyc + 6, 10'b1000000_100);
    wait_cycles(8);
    enable = 1'b0;
    #1;
    check("t6_held_until_edge", 32'(key_held), 32'd1);
    wait_cycles(1);
    check("t6_dis_nap", 32'(note_and_pitch), 32'd0);
    check("t6_dis_held", 32'(key_held), 32'd0);
    wait_cycles(1);
    enable = 1'b1;
    expect_strobe(cyc + 4, 10'b1000000_100);
    wait_cycles(8);
    keys = '0;
    wait_cycles(8);

`ifdef NOTE_REPEAT_EN
    // Auto-repeat while held
    octave = 2'b01;
    wait_cycles(3);
    keys = 7'b0000001;
    expect_strobe(cyc + 6,  10'b0000001_010);
    expect_strobe(cyc + 16, 10'b0000001_010);
    expect_strobe(cyc + 26, 10'b0000001_010);
    expect_strobe(cyc + 36, 10'b0000001_010);
    wait_cycles(41);
    keys = '0;
    wait_cycles(8);
`endif

    wait_cycles(4);
    check("pending_strobes", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
